// File: rtl/pingpong_wr_ctrl.sv
// Write-side controller for a two-bank (ping-pong) buffer.
// Takes a valid/ready word stream, fills bank 0 and bank 1 in strict
// alternation, drives the demux data/select plus per-bank write strobes,
// and holds each closed bank until the consumer releases it.
module pingpong_wr_ctrl #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic              in_last,
    output logic [WIDTH-1:0]  d_out,
    output logic              sel,
    output logic              wr_en0,
    output logic              wr_en1,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [1:0]        full,
    output logic [ADDR_W:0]   cnt0,
    output logic [ADDR_W:0]   cnt1,
    input  logic [1:0]        rd_done
);

    // Address of the last slot in a bank; reaching it closes the bank.
    localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(DEPTH - 1);

    // Registered state and outputs.
    logic              wb_r;
    logic [ADDR_W-1:0] ptr_r;
    logic [1:0]        full_r;
    logic [ADDR_W:0]   cnt0_r;
    logic [ADDR_W:0]   cnt1_r;
    logic [WIDTH-1:0]  d_out_r;
    logic              sel_r;
    logic              wr_en0_r;
    logic              wr_en1_r;
    logic [ADDR_W-1:0] wr_addr_r;

    // Combinational helpers derived from registered state and inputs.
    logic              ready_s;
    logic              accept_s;
    logic              close_s;
    logic [1:0]        close_mask_s;
    logic [1:0]        full_nxt_s;
    logic [ADDR_W:0]   cnt_close_s;

    // The bank being filled is writable as long as the consumer does not own it.
    assign ready_s     = ~full_r[wb_r];
    assign accept_s    = in_valid & ready_s;
    assign close_s     = (ptr_r == PTR_LAST) | in_last;
    assign cnt_close_s = {1'b0, ptr_r} + (ADDR_W + 1)'(1'b1);

    // Next ownership flags: releases clear, a closing accept sets the fill bank.
    // A bank being filled is never full, so a release and a close never target
    // the same bank in one cycle.
    always_comb begin
        close_mask_s = 2'b00;
        if (accept_s && close_s) begin
            close_mask_s = wb_r ? 2'b10 : 2'b01;
        end else begin
            close_mask_s = 2'b00;
        end
        full_nxt_s = (full_r & ~rd_done) | close_mask_s;
    end

    // Write-port datapath: strobes pulse one cycle after accept, data/select/address hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_out_r   <= {WIDTH{1'b0}};
            sel_r     <= 1'b0;
            wr_en0_r  <= 1'b0;
            wr_en1_r  <= 1'b0;
            wr_addr_r <= {ADDR_W{1'b0}};
        end else begin
            wr_en0_r <= accept_s & ~wb_r;
            wr_en1_r <= accept_s & wb_r;
            if (accept_s) begin
                d_out_r   <= in_data;
                sel_r     <= wb_r;
                wr_addr_r <= ptr_r;
            end else begin
                d_out_r   <= d_out_r;
                sel_r     <= sel_r;
                wr_addr_r <= wr_addr_r;
            end
        end
    end

    // Bank bookkeeping: fill pointer, active bank, ownership flags and word counts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_r   <= 1'b0;
            ptr_r  <= {ADDR_W{1'b0}};
            full_r <= 2'b00;
            cnt0_r <= {(ADDR_W + 1){1'b0}};
            cnt1_r <= {(ADDR_W + 1){1'b0}};
        end else begin
            full_r <= full_nxt_s;
            if (accept_s && close_s) begin
                ptr_r <= {ADDR_W{1'b0}};
                wb_r  <= ~wb_r;
                if (wb_r) begin
                    cnt1_r <= cnt_close_s;
                end else begin
                    cnt0_r <= cnt_close_s;
                end
            end else if (accept_s) begin
                ptr_r <= ptr_r + ADDR_W'(1'b1);
            end else begin
                ptr_r <= ptr_r;
            end
        end
    end

    assign in_ready = ready_s;
    assign d_out    = d_out_r;
    assign sel      = sel_r;
    assign wr_en0   = wr_en0_r;
    assign wr_en1   = wr_en1_r;
    assign wr_addr  = wr_addr_r;
    assign full     = full_r;
    assign cnt0     = cnt0_r;
    assign cnt1     = cnt1_r;

endmodule

// File: doc/pingpong_wr_ctrl.md
Name: pingpong_wr_ctrl

Overview:
- Write-side controller for a two-bank (ping-pong) on-chip buffer.
- Accepts a valid/ready input word stream and tracks the fill state of bank 0 and bank 1.
- Drives the data word and bank select into the downstream 2-way demultiplexer; that demux steers the word to the bank-0 or bank-1 write port.
- Also issues per-bank write enables and the write address, and holds a bank until its consumer releases it.

Parameters:
- WIDTH, 16, data word width in bits.
- DEPTH, 16, words per bank; must be ≥2.
- ADDR_W, 4, write address width; DEPTH ≤ 2^ADDR_W.

Ports:
- clk  input  1  clock; all logic is rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  controller can accept a word this cycle.
- in_data  input  WIDTH  input word.
- in_last  input  1  qualifies in_data as the last word of a tile; closes the current bank early.
- d_out  output  WIDTH  word to the demux data input.
- sel  output  1  bank select to the demux; 0 = bank 0, 1 = bank 1.
- wr_en0  output  1  write strobe, bank 0.
- wr_en1  output  1  write strobe, bank 1.
- wr_addr  output  ADDR_W  write address within the selected bank.
- full  output  2  full[b] = bank b closed and owned by the consumer.
- cnt0  output  ADDR_W+1  number of valid words in bank 0; meaningful while full[0]=1.
- cnt1  output  ADDR_W+1  number of valid words in bank 1; meaningful while full[1]=1.
- rd_done  input  2  single-cycle pulse per bank; the consumer releases bank b.

Behaviour:
- Reset (async assert, sync deassert):
  - d_out=0, sel=0, wr_en0=wr_en1=0, wr_addr=0, full=2'b00, cnt0=cnt1=0.
  - Internal write bank wb=0 and pointer ptr=0.
  - Reset mid-fill discards the partial bank; no write strobe is issued after reset assertion.
- Ready: in_ready = !full[wb], combinational from registered state only. in_ready never depends on in_valid.
- Accept: occurs when in_valid && in_ready. On the next edge:
  - d_out ← in_data; sel ← wb; wr_addr ← ptr.
  - wr_en0 ← (wb==0); wr_en1 ← (wb==1).
  - Write latency is 1 cycle from accept to strobe.
- No accept: wr_en0 and wr_en1 are 0 next cycle; d_out, sel and wr_addr hold their last values.
- Close condition: (ptr==DEPTH-1) || in_last. On an accept that meets it, the next edge sets:
  - full[wb] ← 1.
  - cnt_wb ← ptr+1.
  - ptr ← 0.
  - wb ← ~wb.
- Otherwise an accept increments ptr. ptr never exceeds DEPTH-1.
- Release: rd_done[b] with full[b]=1 clears full[b] on the next edge; cnt_b holds its value. rd_done[b] with full[b]=0 is ignored.
- Both banks can be released in the same cycle.
- Simultaneous close of bank b and rd_done[b]: not possible, because full[b]=0 while filling. Close of bank b in the same cycle as rd_done[~b]: both take effect.
- Both full: in_ready=0 and the stream stalls. The first release re-enables acceptance one cycle after the rd_done pulse, into bank wb at address 0.
- Bank order strictly alternates 0,1,0,1…; a bank is never skipped even if the other is empty.
- in_last when ptr==DEPTH-1 is a normal close with cnt=DEPTH.

Test Plan:
- Reset: assert rst_n=0 mid-stream, then release → all outputs 0 and in_ready=1 the cycle after release; the next word is written to bank 0, address 0.
- Single bank fill (DEPTH=4): words 0xA0..0xA3 back-to-back → wr_en0 with wr_addr 0..3 and d_out A0..A3, each one cycle after accept. full=01 and cnt0=4 after the 4th. The 5th word 0xB0 gives sel=1, wr_en1, address 0.
- Backpressure (DEPTH=4): 9 words with no rd_done → 8 accepted; after the 8th, full=11 and in_ready=0; the 9th word is held with no strobes issued.
- Release: in the full=11 state, pulse rd_done=01 → full=10 next cycle and in_ready=1. The held word is written with wr_en0 at address 0; cnt1 stays 4.
- Early close: in_last on the 2nd word → full[0]=1, cnt0=2. The following word goes to bank 1, address 0.
- Spurious and dual release: rd_done=10 while full=01 → no change. Then rd_done=11 while full=11 → full=00 next cycle.
